// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN result stage.
package cnn_pkg;

    localparam int unsigned CNN_DATA_BITS = 8;

    localparam logic [1:0] DISP_ROTATE = 2'd0;
    localparam logic [1:0] DISP_INDEX  = 2'd1;
    localparam logic [1:0] DISP_ONEHOT = 2'd2;
    localparam logic [1:0] DISP_MAX    = 2'd3;

    typedef enum logic [1:0] {
        RES_IDLE = 2'd0,
        RES_SCAN = 2'd1,
        RES_HOLD = 2'd2
    } res_state_t;

endpackage

// File: rtl/result_display_seq.sv
// LED display sequencer: dwell counter, wrap-safe rotate index and mode mux.
module result_display_seq
    import cnn_pkg::*;
#(
    parameter int unsigned N_CLASS   = 7,
    parameter int unsigned DATA_BITS = CNN_DATA_BITS,
    parameter int unsigned DWELL     = 10000,
    parameter int unsigned IDX_W     = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [N_CLASS*DATA_BITS-1:0]   snap_i,
    input  logic [IDX_W-1:0]               class_i,
    input  logic [DATA_BITS-1:0]           max_i,
    input  logic [1:0]                     mode_i,
    input  logic                           restart_i,
    output logic [DATA_BITS-1:0]           led_o
);

    localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_CLASS - 1);
    localparam bit ONEHOT_FITS = (N_CLASS <= DATA_BITS);

    logic [CNT_W-1:0]     dwell_cnt, dwell_cnt_nxt;
    logic [IDX_W-1:0]     disp_idx, disp_idx_nxt;
    logic                 have_result;
    logic [DATA_BITS-1:0] scores [N_CLASS];
    logic [DATA_BITS-1:0] led_nxt;

    // Unpack the snapshot into per-class scores
    always_comb begin
        for (int k = 0; k < int'(N_CLASS); k++) begin
            scores[k] = snap_i[k*DATA_BITS +: DATA_BITS];
        end
    end

    // Next dwell count and rotate index; a new result restarts at class 0
    always_comb begin
        dwell_cnt_nxt = dwell_cnt;
        disp_idx_nxt  = disp_idx;
        if (restart_i) begin
            dwell_cnt_nxt = '0;
            disp_idx_nxt  = '0;
        end else if (dwell_cnt == CNT_LAST) begin
            dwell_cnt_nxt = '0;
            disp_idx_nxt  = (disp_idx == IDX_LAST) ? '0 : disp_idx + IDX_W'(1);
        end else begin
            dwell_cnt_nxt = dwell_cnt + CNT_W'(1);
        end
    end

    // Display mux; rotate uses the next index so each class shows exactly DWELL cycles
    always_comb begin
        led_nxt = '0;
        case (mode_i)
            DISP_ROTATE: led_nxt = scores[disp_idx_nxt];
            DISP_INDEX:  led_nxt = DATA_BITS'(class_i);
            DISP_ONEHOT: led_nxt = ONEHOT_FITS ? (DATA_BITS'(1) << class_i) : DATA_BITS'(class_i);
            DISP_MAX:    led_nxt = max_i;
            default:     led_nxt = '0;
        endcase
    end

    // Display registers; LED stays dark until the first result arrives
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dwell_cnt   <= '0;
            disp_idx    <= '0;
            have_result <= 1'b0;
            led_o       <= '0;
        end else begin
            if (restart_i) begin
                have_result <= 1'b1;
            end
            if (restart_i || have_result) begin
                dwell_cnt <= dwell_cnt_nxt;
                disp_idx  <= disp_idx_nxt;
                led_o     <= led_nxt;
            end
        end
    end

endmodule

// File: rtl/cnn_result_unit.sv
// Classification result unit: captures a score vector, finds the argmax one class per cycle.
module cnn_result_unit
    import cnn_pkg::*;
#(
    parameter int unsigned N_CLASS   = 7,
    parameter int unsigned DATA_BITS = CNN_DATA_BITS,
    parameter int unsigned DWELL     = 10000,
    parameter bit          SIGNED    = 1'b1,
    localparam int unsigned IDX_W    = (N_CLASS > 2) ? $clog2(N_CLASS) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           valid_i,
    input  logic [N_CLASS*DATA_BITS-1:0]   data_i,
    input  logic [1:0]                     mode_i,
    output logic                           ready_o,
    output logic                           done_o,
    output logic [IDX_W-1:0]               class_o,
    output logic [DATA_BITS-1:0]           max_o,
    output logic [DATA_BITS-1:0]           led_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASS - 1);

    res_state_t                   state;
    logic [N_CLASS*DATA_BITS-1:0] snap;
    logic [DATA_BITS-1:0]         best;
    logic [IDX_W-1:0]             best_idx;
    logic [IDX_W-1:0]             scan_idx;
    logic [DATA_BITS-1:0]         scores [N_CLASS];
    logic [DATA_BITS-1:0]         cand;
    logic                         cand_gt;

    // Unpack the snapshot into per-class scores
    always_comb begin
        for (int k = 0; k < int'(N_CLASS); k++) begin
            scores[k] = snap[k*DATA_BITS +: DATA_BITS];
        end
    end

    // Strictly-greater compare so ties keep the lowest index
    always_comb begin
        cand    = scores[scan_idx];
        cand_gt = SIGNED ? ($signed(cand) > $signed(best)) : (cand > best);
    end

    // Argmax FSM: accept in IDLE/HOLD, scan classes 1..N_CLASS-1, publish on the last
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RES_IDLE;
            ready_o  <= 1'b1;
            done_o   <= 1'b0;
            class_o  <= '0;
            max_o    <= '0;
            snap     <= '0;
            best     <= '0;
            best_idx <= '0;
            scan_idx <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                RES_IDLE, RES_HOLD: begin
                    if (valid_i) begin
                        snap     <= data_i;
                        best     <= data_i[DATA_BITS-1:0];
                        best_idx <= '0;
                        scan_idx <= IDX_W'(1);
                        ready_o  <= 1'b0;
                        state    <= RES_SCAN;
                    end
                end
                RES_SCAN: begin
                    if (scan_idx == LAST_IDX) begin
                        class_o <= cand_gt ? scan_idx : best_idx;
                        max_o   <= cand_gt ? cand : best;
                        done_o  <= 1'b1;
                        ready_o <= 1'b1;
                        state   <= RES_HOLD;
                    end else begin
                        if (cand_gt) begin
                            best     <= cand;
                            best_idx <= scan_idx;
                        end
                        scan_idx <= scan_idx + IDX_W'(1);
                    end
                end
                default: begin
                    ready_o <= 1'b1;
                    state   <= RES_IDLE;
                end
            endcase
        end
    end

    result_display_seq #(
        .N_CLASS   (N_CLASS),
        .DATA_BITS (DATA_BITS),
        .DWELL     (DWELL),
        .IDX_W     (IDX_W)
    ) u_display (
        .clk       (clk),
        .reset     (reset),
        .snap_i    (snap),
        .class_i   (class_o),
        .max_i     (max_o),
        .mode_i    (mode_i),
        .restart_i (done_o),
        .led_o     (led_o)
    );

endmodule
